// File: rtl/case2_bist_pkg.sv
// Shared types, constants and step functions for the case2 BIST controller.
package case2_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    APPLY   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [15:0] MISR_SEED    = 16'hFFFF;
  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam logic [4:0]  LFSR_SEED    = 5'h01;
  localparam int unsigned NUM_PATTERNS = 32;
  localparam logic [4:0]  LAST_IDX     = 5'(NUM_PATTERNS - 1);

  function automatic logic [4:0] lfsr_next(input logic [4:0] s);
    return {s[3:0], s[4] ^ s[2]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [2:0] d);
    logic [15:0] sh;
    sh = {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000);
    return sh ^ {13'b0, d};
  endfunction

endpackage

// File: rtl/case2_bist_ctrl_if.sv
// Control/observe bus between the BIST sequencer and its 16-bit MISR.
interface case2_bist_ctrl_if;
  logic        clear;
  logic        enable;
  logic [2:0]  data;
  logic [15:0] state;

  modport master (output clear, output enable, output data, input state);
  modport slave  (input clear, input enable, input data, output state);
endinterface

// File: rtl/case2_misr16.sv
// 16-bit MISR compacting 3-bit responses; clear has priority over enable.
module case2_misr16
  import case2_bist_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  case2_bist_ctrl_if.slave bus
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (bus.clear) begin
      sig_d = MISR_SEED;
    end else if (bus.enable) begin
      sig_d = misr_step(sig_q, bus.data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= MISR_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.state = sig_q;

endmodule

// File: rtl/case2_bist_ctrl.sv
// Exhaustive BIST sequencer for case2: LFSR patterns plus all-zero, MISR compaction.
// Define CASE2_BIST_GOLDEN_EN to add golden_sig/pass signature comparison.
module case2_bist_ctrl
  import case2_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [4:0]  stim,
  input  logic [2:0]  resp,
  output logic        busy,
  output logic        done,
  output logic [15:0] signature
`ifdef CASE2_BIST_GOLDEN_EN
  ,
  input  logic [15:0] golden_sig,
  output logic        pass
`endif
);

  case2_bist_ctrl_if misr_bus ();

  case2_misr16 u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (misr_bus)
  );

  state_e      state_q, state_d;
  logic [4:0]  lfsr_q, lfsr_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  stim_q, stim_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef CASE2_BIST_GOLDEN_EN
  logic        pass_q, pass_d;
`endif

  assign misr_bus.clear  = (state_q == IDLE) && start;
  assign misr_bus.enable = (state_q == CAPTURE);
  assign misr_bus.data   = resp;

  // stim is registered, so the next pattern is chosen from the next-state values
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    stim_d  = stim_q;
`ifdef CASE2_BIST_GOLDEN_EN
    pass_d  = pass_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = APPLY;
          lfsr_d  = LFSR_SEED;
          idx_d   = '0;
          stim_d  = LFSR_SEED;
`ifdef CASE2_BIST_GOLDEN_EN
          pass_d  = 1'b0;
`endif
        end
      end
      APPLY: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (idx_q != LAST_IDX) begin
          state_d = APPLY;
          idx_d   = idx_q + 5'd1;
          lfsr_d  = lfsr_next(lfsr_q);
          stim_d  = (idx_d == LAST_IDX) ? '0 : lfsr_d;
        end else begin
          state_d = DONE;
          stim_d  = '0;
`ifdef CASE2_BIST_GOLDEN_EN
          pass_d  = (misr_step(misr_bus.state, resp) == golden_sig);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        stim_d  = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      idx_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CASE2_BIST_GOLDEN_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CASE2_BIST_GOLDEN_EN
      pass_q  <= pass_d;
`endif
    end
  end

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = misr_bus.state;
`ifdef CASE2_BIST_GOLDEN_EN
  assign pass      = pass_q;
`endif

endmodule
